// File: rtl/eth_rx_frame_checker.sv
// eth_rx_frame_checker
//
// Byte-wide receive frame checker for the 8-bit dv/er/data port interface.
// Strips preamble/SFD, captures DA, SA and the last payload byte (sequence
// number), runs CRC-32 over the body and reports one status word per frame.
//
// Parameters:
//   MIN_LEN     minimum body length (DA..FCS inclusive), bytes
//   MAX_LEN     maximum body length, bytes (<= 2047)
//
// Ports:
//   clk         single clock, inputs sampled on rising edge
//   rst_n       asynchronous active-low reset
//   dv, er      data valid / PHY error (er meaningful only with dv=1)
//   data        receive byte
//   frame_done  one-cycle pulse, all status outputs valid in that cycle
//   frame_ok    no error flag set for the frame
//   crc_err, len_err, phy_err, pre_err   per-frame error flags
//   da, sa      destination / source address, first byte in bits [47:40]
//   frame_len   body byte count, saturating at 2047
//   seq         last body byte before the FCS
//   good_cnt, bad_cnt   saturating frame counters
//
// Build option: define ETH_RX_STATS_EN to build the good/bad frame counters;
// without it both counters are tied to zero.

module eth_rx_frame_checker #(
    parameter int unsigned MIN_LEN = 64,
    parameter int unsigned MAX_LEN = 1518
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dv,
    input  logic        er,
    input  logic [7:0]  data,
    output logic        frame_done,
    output logic        frame_ok,
    output logic        crc_err,
    output logic        len_err,
    output logic        phy_err,
    output logic        pre_err,
    output logic [47:0] da,
    output logic [47:0] sa,
    output logic [10:0] frame_len,
    output logic [7:0]  seq,
    output logic [15:0] good_cnt,
    output logic [15:0] bad_cnt
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PRE  = 3'd1;
    localparam logic [2:0] S_BODY = 3'd2;
    localparam logic [2:0] S_DROP = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [10:0] MIN_L = 11'(MIN_LEN);
    localparam logic [10:0] MAX_L = 11'(MAX_LEN);

    // Bit-reversed form of 0x04C11DB7 for the right-shifting register.
    localparam logic [31:0] CRC_POLY_REFL = 32'hEDB88320;

    logic [2:0]  state;
    logic [2:0]  pre_cnt;
    logic [10:0] byte_cnt;
    logic [31:0] crc;
    logic [31:0] dline;      // [31:24] is the oldest byte
    logic        phy_acc;
    logic [47:0] da_sh;
    logic [47:0] sa_sh;
    logic [7:0]  seq_sh;

    logic        short_body;
    logic        body_crc_err;
    logic        body_len_err;

    // Reflected byte update with the byte bit-reversed first: data[7] is
    // the first bit shifted in.
    function automatic logic [31:0] crc_step(input logic [31:0] c_in,
                                             input logic [7:0]  d);
        logic [31:0] c;
        c = c_in;
        for (int unsigned i = 0; i < 8; i++) begin
            if (c[0] ^ d[7-i])
                c = {1'b0, c[31:1]} ^ CRC_POLY_REFL;
            else
                c = {1'b0, c[31:1]};
        end
        return c;
    endfunction

    always_comb begin
        short_body   = (byte_cnt < 11'd5);
        body_crc_err = short_body || (crc != dline);
        body_len_err = (byte_cnt < MIN_L) || (byte_cnt > MAX_L);
    end

    assign frame_done = (state == S_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            pre_cnt   <= '0;
            byte_cnt  <= '0;
            crc       <= '1;
            dline     <= '0;
            phy_acc   <= 1'b0;
            da_sh     <= '0;
            sa_sh     <= '0;
            seq_sh    <= '0;
            frame_ok  <= 1'b0;
            crc_err   <= 1'b0;
            len_err   <= 1'b0;
            phy_err   <= 1'b0;
            pre_err   <= 1'b0;
            da        <= '0;
            sa        <= '0;
            frame_len <= '0;
            seq       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (dv) begin
                        phy_acc <= er;
                        if (data == 8'h55) begin
                            state   <= S_PRE;
                            pre_cnt <= 3'd1;
                        end else begin
                            state <= S_DROP;
                        end
                    end
                end

                S_PRE: begin
                    if (!dv) begin
                        state <= S_IDLE;
                    end else begin
                        phy_acc <= phy_acc | er;
                        if (data == 8'h55) begin
                            if (pre_cnt == 3'd7)
                                state <= S_DROP;
                            else
                                pre_cnt <= pre_cnt + 3'd1;
                        end else if (data == 8'hD5) begin
                            state    <= S_BODY;
                            byte_cnt <= '0;
                            crc      <= '1;
                        end else begin
                            state <= S_DROP;
                        end
                    end
                end

                S_BODY: begin
                    if (dv) begin
                        phy_acc <= phy_acc | er;
                        if (byte_cnt != '1)
                            byte_cnt <= byte_cnt + 11'd1;
                        for (int unsigned i = 0; i < 6; i++) begin
                            if (byte_cnt == 11'(i))
                                da_sh[8*(5-i) +: 8] <= data;
                            if (byte_cnt == 11'(i + 6))
                                sa_sh[8*(5-i) +: 8] <= data;
                        end
                        dline <= {dline[23:0], data};
                        // The delay line is full from index 4 on; saturation
                        // of byte_cnt keeps this true so the CRC keeps running.
                        if (byte_cnt >= 11'd4) begin
                            crc    <= crc_step(crc, dline[31:24]);
                            seq_sh <= dline[31:24];
                        end
                    end else begin
                        // Status registers load on entry to DONE so they are
                        // valid during the frame_done cycle.
                        state     <= S_DONE;
                        frame_len <= byte_cnt;
                        crc_err   <= body_crc_err;
                        len_err   <= body_len_err;
                        phy_err   <= phy_acc;
                        pre_err   <= 1'b0;
                        frame_ok  <= ~(body_crc_err | body_len_err | phy_acc);
                        da        <= da_sh;
                        sa        <= sa_sh;
                        seq       <= short_body ? '0 : seq_sh;
                    end
                end

                S_DROP: begin
                    if (dv) begin
                        phy_acc <= phy_acc | er;
                    end else begin
                        state     <= S_DONE;
                        frame_len <= '0;
                        crc_err   <= 1'b0;
                        len_err   <= 1'b0;
                        phy_err   <= phy_acc;
                        pre_err   <= 1'b1;
                        frame_ok  <= 1'b0;
                    end
                end

                S_DONE: begin
                    if (dv && (data == 8'h55)) begin
                        state   <= S_PRE;
                        pre_cnt <= 3'd1;
                        phy_acc <= er;
                    end else begin
                        state <= S_IDLE;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef ETH_RX_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            good_cnt <= '0;
            bad_cnt  <= '0;
        end else if (state == S_DONE) begin
            if (frame_ok) begin
                if (good_cnt != '1)
                    good_cnt <= good_cnt + 16'd1;
            end else begin
                if (bad_cnt != '1)
                    bad_cnt <= bad_cnt + 16'd1;
            end
        end
    end
`else
    assign good_cnt = '0;
    assign bad_cnt  = '0;
`endif

endmodule

// File: tb/tb_eth_rx_frame_checker.sv
module tb_eth_rx_frame_checker;

    localparam int MIN_LEN = 64;
    localparam int MAX_LEN = 1518;
`ifdef ETH_RX_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        dv;
    logic        er;
    logic [7:0]  data;
    logic        frame_done;
    logic        frame_ok;
    logic        crc_err;
    logic        len_err;
    logic        phy_err;
    logic        pre_err;
    logic [47:0] da;
    logic [47:0] sa;
    logic [10:0] frame_len;
    logic [7:0]  seq;
    logic [15:0] good_cnt;
    logic [15:0] bad_cnt;

    eth_rx_frame_checker #(.MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN)) dut (
        .clk(clk), .rst_n(rst_n), .dv(dv), .er(er), .data(data),
        .frame_done(frame_done), .frame_ok(frame_ok),
        .crc_err(crc_err), .len_err(len_err), .phy_err(phy_err), .pre_err(pre_err),
        .da(da), .sa(sa), .frame_len(frame_len), .seq(seq),
        .good_cnt(good_cnt), .bad_cnt(bad_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [10:0] len;
        logic        crc_e, len_e, phy_e, pre_e, ok;
        logic [47:0] da, sa;
        logic [7:0]  seq;
        int          done_cyc;
        logic [15:0] good, bad;
    } exp_t;

    exp_t        exp_q[$];
    logic [7:0]  bq[$];     // body under construction
    logic [7:0]  fb[$];     // full dv=1 byte sequence of one frame
    logic        fe[$];     // er per byte of fb

    int checks = 0;
    int failures = 0;

    // persistent reference state
    logic [47:0] m_da = '0, m_sa = '0;
    logic [7:0]  m_seq = '0;
    logic [15:0] m_good = '0, m_bad = '0;

    function void chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endfunction

    // CRC-32 from its definition: MSB-first division by 0x04C11DB7, init all
    // ones, no final inversion; the register is reported bit-reversed.
    function automatic logic [31:0] crc_of(input logic [7:0] q[$], input int start, input int cnt);
        logic [31:0] n;
        logic [31:0] r;
        logic [7:0]  b;
        logic        fbk;
        n = '1;
        for (int i = 0; i < cnt; i++) begin
            b = q[start + i];
            for (int j = 7; j >= 0; j--) begin
                fbk = n[31] ^ b[j];
                n = {n[30:0], 1'b0};
                if (fbk) n = n ^ 32'h04C11DB7;
            end
        end
        for (int k = 0; k < 32; k++) r[k] = n[31 - k];
        return r;
    endfunction

    // ---------------- monitor / scoreboard ----------------
    logic        cnt_pending = 1'b0;
    logic [15:0] cnt_good_req, cnt_bad_req;

    always @(negedge clk) begin
        exp_t e;
        if (cnt_pending) begin
            chk("good_cnt", 64'(good_cnt), 64'(cnt_good_req));
            chk("bad_cnt", 64'(bad_cnt), 64'(cnt_bad_req));
            cnt_pending = 1'b0;
        end
        if (rst_n && frame_done) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_frame_done actual=1 required=0 (t=%0t)", $time);
            end else begin
                e = exp_q.pop_front();
                chk("done_cycle", 64'(cyc), 64'(e.done_cyc));
                chk("frame_len", 64'(frame_len), 64'(e.len));
                chk("crc_err", 64'(crc_err), 64'(e.crc_e));
                chk("len_err", 64'(len_err), 64'(e.len_e));
                chk("phy_err", 64'(phy_err), 64'(e.phy_e));
                chk("pre_err", 64'(pre_err), 64'(e.pre_e));
                chk("frame_ok", 64'(frame_ok), 64'(e.ok));
                chk("da", 64'(da), 64'(e.da));
                chk("sa", 64'(sa), 64'(e.sa));
                chk("seq", 64'(seq), 64'(e.seq));
                cnt_good_req = e.good;
                cnt_bad_req  = e.bad;
                cnt_pending  = 1'b1;
            end
        end
    end

    // ---------------- reference model ----------------
    task automatic model_push(input int done_cyc);
        exp_t e;
        int   n, len, st;
        logic phy;
        logic [31:0] r;
        n = 0;
        while (n < fb.size() && fb[n] == 8'h55) n++;
        phy = 1'b0;
        foreach (fe[i]) phy = phy | fe[i];
        if (n >= 1 && n <= 7 && n == fb.size()) return;   // preamble only: silent
        e.phy_e = phy;
        if (n >= 1 && n <= 7 && fb[n] == 8'hD5) begin
            st  = n + 1;
            len = fb.size() - st;
            e.pre_e = 1'b0;
            e.len   = (len > 2047) ? 11'd2047 : 11'(len);
            e.len_e = (len < MIN_LEN) || (len > MAX_LEN);
            if (len < 5) begin
                e.crc_e = 1'b1;
                m_seq = '0;
            end else begin
                r = crc_of(fb, st, len - 4);
                e.crc_e = (r != {fb[st+len-4], fb[st+len-3], fb[st+len-2], fb[st+len-1]});
                m_seq = fb[st + len - 5];
            end
            for (int i = 0; i < len && i < 12; i++) begin
                if (i < 6) m_da[8*(5-i) +: 8] = fb[st + i];
                else       m_sa[8*(11-i) +: 8] = fb[st + i];
            end
        end else begin
            e.pre_e = 1'b1;
            e.len   = '0;
            e.crc_e = 1'b0;
            e.len_e = 1'b0;
        end
        e.ok = ~(e.crc_e | e.len_e | e.phy_e | e.pre_e);
        if (e.ok) begin if (m_good != 16'hFFFF) m_good++; end
        else      begin if (m_bad  != 16'hFFFF) m_bad++;  end
        e.da = m_da;
        e.sa = m_sa;
        e.seq = m_seq;
        e.done_cyc = done_cyc;
        e.good = STATS ? m_good : 16'h0;
        e.bad  = STATS ? m_bad  : 16'h0;
        exp_q.push_back(e);
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic v, input logic e, input logic [7:0] d);
        @(posedge clk);
        #1;
        dv = v;
        er = e;
        data = d;
    endtask

    task automatic fill_rand(input int n);
        bq.delete();
        repeat (n) bq.push_back(8'($urandom));
    endtask

    // mode 1: valid FCS, mode 2: FCS with LSB of last byte flipped
    task automatic seal(input int mode);
        logic [31:0] r;
        r = crc_of(bq, 0, bq.size());
        if (mode == 2) r[0] = ~r[0];
        bq.push_back(r[31:24]);
        bq.push_back(r[23:16]);
        bq.push_back(r[15:8]);
        bq.push_back(r[7:0]);
    endtask

    task automatic assemble(input int pre_n);
        fb.delete();
        fe.delete();
        repeat (pre_n) begin fb.push_back(8'h55); fe.push_back(1'b0); end
        fb.push_back(8'hD5);
        fe.push_back(1'b0);
        foreach (bq[i]) begin fb.push_back(bq[i]); fe.push_back(1'b0); end
    endtask

    task automatic send(input int gap);
        for (int i = 0; i < fb.size(); i++) drive(1'b1, fe[i], fb[i]);
        drive(1'b0, 1'($urandom), 8'($urandom));
        model_push(cyc + 1);
        for (int g = 1; g < gap; g++) drive(1'b0, 1'($urandom), 8'($urandom));
    endtask

    task automatic build_plan_frame(input int mode);
        bq.delete();
        bq = '{8'h02, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00,
               8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
        repeat (1375) bq.push_back(8'h00);
        bq.push_back(8'h2A);
        seal(mode);
    endtask

    task automatic check_zero_state(input string tag);
        chk({tag, "_frame_done"}, 64'(frame_done), 64'd0);
        chk({tag, "_frame_ok"}, 64'(frame_ok), 64'd0);
        chk({tag, "_flags"}, 64'({crc_err, len_err, phy_err, pre_err}), 64'd0);
        chk({tag, "_da"}, 64'(da), 64'd0);
        chk({tag, "_sa"}, 64'(sa), 64'd0);
        chk({tag, "_frame_len"}, 64'(frame_len), 64'd0);
        chk({tag, "_seq"}, 64'(seq), 64'd0);
        chk({tag, "_counters"}, 64'({good_cnt, bad_cnt}), 64'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int lens[7];
        int t;
        rst_n = 1'b0;
        dv = 1'b0;
        er = 1'b0;
        data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_zero_state("reset");

        // test-plan good frame, then FCS LSB flipped
        build_plan_frame(1); assemble(7); send(1);
        build_plan_frame(2); assemble(7); send(1);

        // length limits
        fill_rand(36);   seal(1); assemble(7); send(1);
        fill_rand(1515); seal(1); assemble(7); send(1);

        // preamble errors
        fb.delete(); fe.delete();
        fb = '{8'h55, 8'h54, 8'h12, 8'h34, 8'hD5, 8'h00, 8'h99};
        repeat (7) fe.push_back(1'b0);
        send(1);
        fill_rand(60); seal(1); assemble(8); send(1);

        // one body cycle with er=1
        fill_rand(60); seal(1); assemble(7); fe[20] = 1'b1; send(1);

        // three good frames back to back
        for (int i = 0; i < 3; i++) begin
            fill_rand($urandom_range(60, 100)); seal(1); assemble(7); send(1);
        end

        // body length boundaries and very short bodies
        lens = '{0, 3, 4, 5, 63, 64, 1518};
        foreach (lens[i]) begin
            if (lens[i] >= 4) begin fill_rand(lens[i] - 4); seal(1); end
            else fill_rand(lens[i]);
            assemble(1 + i % 7);
            send(1);
        end

        // saturating length, CRC still running
        fill_rand(2096); seal(1); assemble(7); send(2);

        // preamble-only burst: no status expected
        fb.delete(); fe.delete();
        repeat (3) begin fb.push_back(8'h55); fe.push_back(1'b0); end
        send(2);

        // randomized traffic
        for (int f = 0; f < 40; f++) begin
            int pre_n, len, sel;
            pre_n = ($urandom_range(0, 4) != 0) ? $urandom_range(1, 7) : $urandom_range(8, 9);
            sel = $urandom_range(0, 2);
            len = (sel == 0) ? $urandom_range(0, 8) :
                  (sel == 1) ? $urandom_range(60, 68) : $urandom_range(9, 200);
            if (len >= 4 && $urandom_range(0, 3) != 0) begin
                fill_rand(len - 4);
                seal($urandom_range(0, 4) == 0 ? 2 : 1);
            end else begin
                fill_rand(len);
            end
            assemble(pre_n);
            if ($urandom_range(0, 9) == 0) fb[$urandom_range(1, pre_n)] = 8'($urandom);
            foreach (fe[i]) fe[i] = ($urandom_range(0, 49) == 0);
            send($urandom_range(1, 3));
        end

        // drain before the reset test
        t = 0;
        while (exp_q.size() > 0 && t < 5000) begin @(posedge clk); t++; end
        chk("drain_before_reset", 64'(exp_q.size()), 64'd0);
        repeat (3) @(posedge clk);

        // reset in the middle of a body
        fill_rand(196); seal(1); assemble(7);
        for (int i = 0; i < 70; i++) drive(1'b1, fe[i], fb[i]);
        #2;
        rst_n = 1'b0;
        dv = 1'b0;
        m_da = '0; m_sa = '0; m_seq = '0; m_good = '0; m_bad = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_zero_state("midreset");
        repeat (4) @(negedge clk);
        chk("midreset_no_done_counters", 64'({good_cnt, bad_cnt}), 64'd0);

        // next frame checks clean
        fill_rand(80); seal(1); assemble(7); send(1);

        t = 0;
        while (exp_q.size() > 0 && t < 5000) begin @(posedge clk); t++; end
        chk("drain_final", 64'(exp_q.size()), 64'd0);
        repeat (5) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
